ctrl_pipe: RTL and testbench



---
 rtl/ctrl_pipe.sv | 164 ++++++++++++++++
 tb/tb_ctrl_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// RV32I pipeline control: decodes ID into the control bundle and carries it through EX/MEM/WB,
// resolving load-use stalls, redirect flushes and global hold on control state only.
module ctrl_pipe #(
    parameter int REG_AW        = 5,
    parameter bit ENABLE_CSR    = 1'b1,
    parameter bit STRICT_DECODE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_id_valid,
    input  logic [31:0]       i_id_inst,
    input  logic              i_hold,
    input  logic              i_ex_redirect,
    output logic              o_id_stall,
    output logic              o_illegal,
    output logic [11:0]       o_ex_ctrl,
    output logic [11:0]       o_mem_ctrl,
    output logic [11:0]       o_wb_ctrl,
    output logic              o_ex_valid,
    output logic              o_mem_valid,
    output logic              o_wb_valid,
    output logic [REG_AW-1:0] o_ex_rd,
    output logic [REG_AW-1:0] o_mem_rd,
    output logic [REG_AW-1:0] o_wb_rd
);

    localparam logic [6:0] OPC_BR     = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Bundle bit positions: {is_csr, is_auipc, is_lui, is_jalr, is_jal, reg_wen,
    //                        alu_src, mem_wen, alu_op, mem2reg, mem_read, is_branch}
    localparam int CB_MEM_READ = 1;
    localparam int CB_REG_WEN  = 6;

    localparam logic [REG_AW-1:0] RD_ZERO = {REG_AW{1'b0}};

    logic [6:0]        w_opc;
    logic [REG_AW-1:0] w_id_rd;
    logic [REG_AW-1:0] w_id_rs1;
    logic [REG_AW-1:0] w_id_rs2;
    logic              w_unused;

    logic w_op_br, w_op_load, w_op_store, w_op_op, w_op_imm;
    logic w_op_jal, w_op_jalr, w_op_lui, w_op_auipc, w_op_sys;
    logic w_known;
    logic w_reg_wen;
    logic w_rs1_used;
    logic w_rs2_used;
    logic w_bubble;

    logic [11:0]       w_dec_ctrl;
    logic [REG_AW-1:0] w_dec_rd;
    logic              w_nx_ex_valid;
    logic [11:0]       w_nx_ex_ctrl;
    logic [REG_AW-1:0] w_nx_ex_rd;

    logic              r_ex_valid, r_mem_valid, r_wb_valid;
    logic [11:0]       r_ex_ctrl, r_mem_ctrl, r_wb_ctrl;
    logic [REG_AW-1:0] r_ex_rd, r_mem_rd, r_wb_rd;

    assign w_opc    = i_id_inst[6:0];
    assign w_id_rd  = REG_AW'(i_id_inst[11:7]);
    assign w_id_rs1 = REG_AW'(i_id_inst[19:15]);
    assign w_id_rs2 = REG_AW'(i_id_inst[24:20]);
    assign w_unused = ^{i_id_inst[31:25], i_id_inst[14:12]};

    assign w_op_br    = (w_opc == OPC_BR);
    assign w_op_load  = (w_opc == OPC_LOAD);
    assign w_op_store = (w_opc == OPC_STORE);
    assign w_op_op    = (w_opc == OPC_OP);
    assign w_op_imm   = (w_opc == OPC_OPIMM);
    assign w_op_jal   = (w_opc == OPC_JAL);
    assign w_op_jalr  = (w_opc == OPC_JALR);
    assign w_op_lui   = (w_opc == OPC_LUI);
    assign w_op_auipc = (w_opc == OPC_AUIPC);
    assign w_op_sys   = (w_opc == OPC_SYSTEM);

    // SYSTEM only counts as a known opcode when CSR support is built in.
    assign w_known = w_op_br | w_op_load | w_op_store | w_op_op | w_op_imm | w_op_jal
                   | w_op_jalr | w_op_lui | w_op_auipc | (w_op_sys & ENABLE_CSR);

    assign w_reg_wen = (w_op_op | w_op_imm | w_op_load | w_op_jal | w_op_jalr | w_op_lui
                        | w_op_auipc | (w_op_sys & ENABLE_CSR)) & (w_id_rd != RD_ZERO);

    assign w_dec_ctrl = {w_op_sys & ENABLE_CSR, w_op_auipc, w_op_lui, w_op_jalr, w_op_jal,
                         w_reg_wen, w_op_op | w_op_br, w_op_store,
                         w_op_op | w_op_imm | w_op_load | w_op_store,
                         w_op_load, w_op_load, w_op_br};
    assign w_dec_rd   = w_reg_wen ? w_id_rd : RD_ZERO;

    assign w_rs1_used = w_op_op | w_op_imm | w_op_load | w_op_store | w_op_br | w_op_jalr | w_op_sys;
    assign w_rs2_used = w_op_op | w_op_store | w_op_br;

    assign o_id_stall = i_id_valid & r_ex_valid & r_ex_ctrl[CB_MEM_READ] & (r_ex_rd != RD_ZERO)
                      & ((w_rs1_used & (w_id_rs1 == r_ex_rd)) | (w_rs2_used & (w_id_rs2 == r_ex_rd)));

    assign o_illegal = i_id_valid & ~w_known & ~i_hold & ~i_ex_redirect & ~o_id_stall;

    assign w_bubble = i_ex_redirect | o_id_stall | ~i_id_valid | (~w_known & STRICT_DECODE);

    // Select what enters EX: the decoded bundle or an all-zero bubble.
    always_comb begin
        w_nx_ex_valid = 1'b0;
        w_nx_ex_ctrl  = 12'h000;
        w_nx_ex_rd    = RD_ZERO;
        if (w_bubble) begin
            w_nx_ex_valid = 1'b0;
            w_nx_ex_ctrl  = 12'h000;
            w_nx_ex_rd    = RD_ZERO;
        end else begin
            w_nx_ex_valid = 1'b1;
            w_nx_ex_ctrl  = w_dec_ctrl;
            w_nx_ex_rd    = w_dec_rd;
        end
    end

    // Stage registers: reset clears everything, hold freezes, otherwise shift one stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_ex_ctrl   <= 12'h000;
            r_mem_ctrl  <= 12'h000;
            r_wb_ctrl   <= 12'h000;
            r_ex_rd     <= RD_ZERO;
            r_mem_rd    <= RD_ZERO;
            r_wb_rd     <= RD_ZERO;
        end else if (!i_hold) begin
            r_wb_valid  <= r_mem_valid;
            r_wb_ctrl   <= r_mem_ctrl;
            r_wb_rd     <= r_mem_rd;
            r_mem_valid <= r_ex_valid;
            r_mem_ctrl  <= r_ex_ctrl;
            r_mem_rd    <= r_ex_rd;
            r_ex_valid  <= w_nx_ex_valid;
            r_ex_ctrl   <= w_nx_ex_ctrl;
            r_ex_rd     <= w_nx_ex_rd;
        end
    end

    assign o_ex_valid  = r_ex_valid;
    assign o_mem_valid = r_mem_valid;
    assign o_wb_valid  = r_wb_valid;
    assign o_ex_ctrl   = r_ex_ctrl;
    assign o_mem_ctrl  = r_mem_ctrl;
    assign o_wb_ctrl   = r_wb_ctrl;
    assign o_ex_rd     = r_ex_rd;
    assign o_mem_rd    = r_mem_rd;
    assign o_wb_rd     = r_wb_rd;

    // Reg-write enable must never reach the pipe for a bundle whose rd was cleared.
    logic w_unused_regwen;
    assign w_unused_regwen = w_dec_ctrl[CB_REG_WEN] & w_unused;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: default build (CSR on, strict) plus a CSR-off, non-strict build.
module tb_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_inst;
    logic        hold;
    logic        ex_redirect;

    logic        a_stall, a_ill, a_exv, a_memv, a_wbv;
    logic [11:0] a_exc, a_memc, a_wbc;
    logic [4:0]  a_exrd, a_memrd, a_wbrd;
    logic        b_stall, b_ill, b_exv, b_memv, b_wbv;
    logic [11:0] b_exc, b_memc, b_wbc;
    logic [4:0]  b_exrd, b_memrd, b_wbrd;

    int errors = 0;
    int checks = 0;

    localparam logic [11:0] C_OP    = 12'h068;
    localparam logic [11:0] C_OPIMM = 12'h048;
    localparam logic [11:0] C_LOAD  = 12'h04E;
    localparam logic [11:0] C_LD_X0 = 12'h00E;
    localparam logic [11:0] C_STORE = 12'h018;
    localparam logic [11:0] C_LUI   = 12'h240;
    localparam logic [11:0] C_JAL   = 12'h0C0;
    localparam logic [11:0] C_CSR   = 12'h840;

    ctrl_pipe #(.REG_AW(5), .ENABLE_CSR(1'b1), .STRICT_DECODE(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_id_valid(id_valid), .i_id_inst(id_inst),
        .i_hold(hold), .i_ex_redirect(ex_redirect), .o_id_stall(a_stall), .o_illegal(a_ill),
        .o_ex_ctrl(a_exc), .o_mem_ctrl(a_memc), .o_wb_ctrl(a_wbc),
        .o_ex_valid(a_exv), .o_mem_valid(a_memv), .o_wb_valid(a_wbv),
        .o_ex_rd(a_exrd), .o_mem_rd(a_memrd), .o_wb_rd(a_wbrd));

    ctrl_pipe #(.REG_AW(5), .ENABLE_CSR(1'b0), .STRICT_DECODE(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_id_valid(id_valid), .i_id_inst(id_inst),
        .i_hold(hold), .i_ex_redirect(ex_redirect), .o_id_stall(b_stall), .o_illegal(b_ill),
        .o_ex_ctrl(b_exc), .o_mem_ctrl(b_memc), .o_wb_ctrl(b_wbc),
        .o_ex_valid(b_exv), .o_mem_valid(b_memv), .o_wb_valid(b_wbv),
        .o_ex_rd(b_exrd), .o_mem_rd(b_memrd), .o_wb_rd(b_wbrd));

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, opc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ex(input string tag, input logic v, input logic [11:0] c, input logic [4:0] r);
        chk({tag, ".ex_valid"}, 32'(a_exv), 32'(v));
        chk({tag, ".ex_ctrl"},  32'(a_exc), 32'(c));
        chk({tag, ".ex_rd"},    32'(a_exrd), 32'(r));
    endtask

    task automatic chk_mem(input string tag, input logic v, input logic [11:0] c, input logic [4:0] r);
        chk({tag, ".mem_valid"}, 32'(a_memv), 32'(v));
        chk({tag, ".mem_ctrl"},  32'(a_memc), 32'(c));
        chk({tag, ".mem_rd"},    32'(a_memrd), 32'(r));
    endtask

    task automatic chk_wb(input string tag, input logic v, input logic [11:0] c, input logic [4:0] r);
        chk({tag, ".wb_valid"}, 32'(a_wbv), 32'(v));
        chk({tag, ".wb_ctrl"},  32'(a_wbc), 32'(c));
        chk({tag, ".wb_rd"},    32'(a_wbrd), 32'(r));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b1; hold = 1'b0; ex_redirect = 1'b0;
        id_inst = mk(7'b0110011, 5'd3, 5'd1, 5'd2);
        tick; tick;
        chk_ex("rst", 1'b0, 12'h000, 5'd0);
        chk_mem("rst", 1'b0, 12'h000, 5'd0);
        chk_wb("rst", 1'b0, 12'h000, 5'd0);
        chk("rst.stall", 32'(a_stall), 32'd0);

        // ADD x3 flows ID->EX->MEM->WB
        rst_n = 1'b1;
        tick;
        chk_ex("add", 1'b1, C_OP, 5'd3);
        id_valid = 1'b0;
        tick;
        chk_mem("add", 1'b1, C_OP, 5'd3);
        chk_ex("add.bub", 1'b0, 12'h000, 5'd0);
        tick;
        chk_wb("add", 1'b1, C_OP, 5'd3);

        // load-use on rs1
        id_valid = 1'b1; id_inst = mk(7'b0000011, 5'd5, 5'd1, 5'd0);
        tick;
        chk_ex("ld5", 1'b1, C_LOAD, 5'd5);
        id_inst = mk(7'b0110011, 5'd6, 5'd5, 5'd1);
        #1 chk("lu.stall", 32'(a_stall), 32'd1);
        chk("lu.noill", 32'(a_ill), 32'd0);
        tick;
        chk_ex("lu.bubble", 1'b0, 12'h000, 5'd0);
        chk_mem("lu.ld", 1'b1, C_LOAD, 5'd5);
        chk("lu.stall_off", 32'(a_stall), 32'd0);
        tick;
        chk_ex("lu.op", 1'b1, C_OP, 5'd6);

        // load to x0 never stalls
        id_inst = mk(7'b0000011, 5'd0, 5'd1, 5'd0);
        tick;
        chk_ex("ldx0", 1'b1, C_LD_X0, 5'd0);
        id_inst = mk(7'b0110011, 5'd6, 5'd0, 5'd1);
        #1 chk("ldx0.stall", 32'(a_stall), 32'd0);
        tick;
        chk_ex("ldx0.op", 1'b1, C_OP, 5'd6);

        // store rs2 hazard
        id_inst = mk(7'b0000011, 5'd7, 5'd1, 5'd0);
        tick;
        id_inst = mk(7'b0100011, 5'd0, 5'd2, 5'd7);
        #1 chk("st.stall", 32'(a_stall), 32'd1);
        tick;
        chk("st.bub_valid", 32'(a_exv), 32'd0);
        tick;
        chk_ex("st", 1'b1, C_STORE, 5'd0);

        // LUI uses no source registers
        id_inst = mk(7'b0000011, 5'd7, 5'd1, 5'd0);
        tick;
        id_inst = mk(7'b0110111, 5'd7, 5'd7, 5'd7);
        #1 chk("lui.stall", 32'(a_stall), 32'd0);
        tick;
        chk_ex("lui", 1'b1, C_LUI, 5'd7);

        // redirect drops the ID instruction only
        id_inst = mk(7'b1101111, 5'd1, 5'd0, 5'd0);
        tick;
        chk_ex("jal", 1'b1, C_JAL, 5'd1);
        id_inst = mk(7'b0110011, 5'd3, 5'd1, 5'd2);
        ex_redirect = 1'b1;
        tick;
        ex_redirect = 1'b0;
        chk_ex("redir", 1'b0, 12'h000, 5'd0);
        chk_mem("redir.jal", 1'b1, C_JAL, 5'd1);

        // stall and redirect together: one bubble only
        id_inst = mk(7'b0000011, 5'd5, 5'd1, 5'd0);
        tick;
        id_inst = mk(7'b0110011, 5'd6, 5'd5, 5'd1);
        ex_redirect = 1'b1;
        #1 chk("sr.stall", 32'(a_stall), 32'd1);
        tick;
        ex_redirect = 1'b0;
        chk("sr.bub", 32'(a_exv), 32'd0);
        tick;
        chk_ex("sr.op", 1'b1, C_OP, 5'd6);

        // fill pipe, then hold 3 cycles with redirect and an unknown opcode in ID
        id_inst = mk(7'b0110011, 5'd3, 5'd1, 5'd2);
        tick;
        id_inst = mk(7'b0010011, 5'd4, 5'd1, 5'd0);
        tick;
        id_inst = mk(7'b0110111, 5'd9, 5'd0, 5'd0);
        tick;
        hold = 1'b1; ex_redirect = 1'b1;
        id_inst = 32'h0000007F;
        #1 chk("hold.noill", 32'(a_ill), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_ex("hold", 1'b1, C_LUI, 5'd9);
            chk_mem("hold", 1'b1, C_OPIMM, 5'd4);
            chk_wb("hold", 1'b1, C_OP, 5'd3);
        end
        hold = 1'b0;
        id_inst = mk(7'b0110011, 5'd3, 5'd1, 5'd2);
        tick;
        ex_redirect = 1'b0;
        chk_ex("hold.flush", 1'b0, 12'h000, 5'd0);
        chk_mem("hold.flush", 1'b1, C_LUI, 5'd9);
        chk_wb("hold.flush", 1'b1, C_OPIMM, 5'd4);

        // unknown opcode: strict bubbles, non-strict passes zero control
        id_inst = mk(7'b1111111, 5'd5, 5'd0, 5'd0);
        #1 chk("ill.a", 32'(a_ill), 32'd1);
        chk("ill.b", 32'(b_ill), 32'd1);
        tick;
        chk_ex("ill.strict", 1'b0, 12'h000, 5'd0);
        chk("ill.b.valid", 32'(b_exv), 32'd1);
        chk("ill.b.ctrl", 32'(b_exc), 32'd0);
        chk("ill.b.rd", 32'(b_exrd), 32'd0);

        // SYSTEM: legal with CSR, illegal and no reg write without
        id_inst = mk(7'b1110011, 5'd5, 5'd1, 5'd0);
        #1 chk("csr.a.ill", 32'(a_ill), 32'd0);
        chk("csr.b.ill", 32'(b_ill), 32'd1);
        tick;
        chk_ex("csr.a", 1'b1, C_CSR, 5'd5);
        chk("csr.b.ctrl", 32'(b_exc), 32'd0);
        chk("csr.b.rd", 32'(b_exrd), 32'd0);
        id_valid = 1'b0;
        #1 chk("ill.pulse_end", 32'(b_ill), 32'd0);
        tick;
        chk("csr.b.memwen", 32'(b_memc[6]), 32'd0);

        // mid-stream reset clears every stage
        id_valid = 1'b1; id_inst = mk(7'b0110011, 5'd3, 5'd1, 5'd2);
        tick; tick;
        rst_n = 1'b0;
        tick;
        chk_ex("mrst", 1'b0, 12'h000, 5'd0);
        chk_mem("mrst", 1'b0, 12'h000, 5'd0);
        chk_wb("mrst", 1'b0, 12'h000, 5'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
